// File: rtl/bram_sd_ctrl.sv
// bram_sd_ctrl
// Backup-RAM save/load sequencer and SD sector-port arbiter.
// The single hps_io sector port is shared between the CD-ROM ISO reader and
// the 8 KB backup RAM. Whole 512-byte sectors move between the HPS save file
// and backup RAM port B. A format request writes the default "HUBM" header.
//
// Ports
//   clk_sys, reset_n         system clock, async active-low reset
//   bk_ena                   writable save image mounted
//   bk_load/bk_save/format   status levels, rising edge = request
//   auto_load                one-cycle load request at end of ROM download
//   busy, loading            backup op in progress / load in progress
//   cd_lba, cd_rd, cd_ack    pcecd_top side of the sector port
//   sd_lba, sd_rd, sd_wr,
//   sd_ack, sd_buff_*        hps_io side of the sector port
//   ram_addr/din/we          backup RAM port B
module bram_sd_ctrl #(
  parameter int SECTORS = 16,
  parameter int LBA_W   = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        bk_ena,
  input  logic        bk_load,
  input  logic        bk_save,
  input  logic        auto_load,
  input  logic        format,
  output logic        busy,
  output logic        loading,
  input  logic [31:0] cd_lba,
  input  logic        cd_rd,
  output logic        cd_ack,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [7:0]  sd_buff_addr,
  input  logic        sd_buff_wr,
  input  logic [15:0] sd_buff_dout,
  output logic [11:0] ram_addr,
  output logic [15:0] ram_din,
  output logic        ram_we
);

  typedef enum logic [2:0] {S_IDLE, S_CD, S_REQ, S_XFER, S_FMT} state_t;

  state_t           state;
  logic             load_d, save_d, fmt_d, ack_d;
  logic             pend_load, pend_save, pend_fmt;
  logic             dir;          // 1 = load (HPS -> RAM)
  logic             rd_r, wr_r;
  logic [LBA_W-1:0] lba;
  logic [1:0]       cnt;

  logic             load_edge, save_edge, fmt_edge, ack_rise, ack_fall;
  logic             idle_free, take_load, take_save, take_fmt, last_sector;
  logic [LBA_W+7:0] xfer_addr;

  assign load_edge = bk_load & ~load_d;
  assign save_edge = bk_save & ~save_d;
  assign fmt_edge  = format  & ~fmt_d;
  assign ack_rise  = sd_ack  & ~ack_d;
  assign ack_fall  = ~sd_ack & ack_d;

  // Ownership only moves in IDLE with the port quiet, so a sector transfer
  // is never split between the CD reader and the backup sequencer.
  assign idle_free = (state == S_IDLE) & ~sd_ack;
  assign take_load = idle_free & ~cd_rd & pend_load;
  assign take_save = idle_free & ~cd_rd & ~pend_load & pend_save;
  assign take_fmt  = idle_free & ~cd_rd & ~pend_load & ~pend_save & pend_fmt;

  assign last_sector = (lba == LBA_W'(SECTORS - 1));
  assign xfer_addr   = {lba, sd_buff_addr};

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      // Delay regs start high: a level held through reset is not an edge.
      load_d    <= 1'b1;
      save_d    <= 1'b1;
      fmt_d     <= 1'b1;
      ack_d     <= 1'b0;
      pend_load <= 1'b0;
      pend_save <= 1'b0;
      pend_fmt  <= 1'b0;
      dir       <= 1'b0;
      rd_r      <= 1'b0;
      wr_r      <= 1'b0;
      lba       <= '0;
      cnt       <= '0;
    end else begin
      load_d <= bk_load;
      save_d <= bk_save;
      fmt_d  <= format;
      ack_d  <= sd_ack;

      // A new edge wins over the clear-on-take; no image means no load/save.
      pend_load <= bk_ena & (load_edge | auto_load | (pend_load & ~take_load));
      pend_save <= bk_ena & (save_edge | (pend_save & ~take_save));
      pend_fmt  <= fmt_edge | (pend_fmt & ~take_fmt);

      case (state)
        S_IDLE: begin
          if (idle_free & cd_rd) begin
            state <= S_CD;
          end else if (take_load | take_save) begin
            lba   <= '0;
            dir   <= take_load;
            rd_r  <= take_load;
            wr_r  <= take_save;
            state <= S_REQ;
          end else if (take_fmt) begin
            cnt   <= '0;
            state <= S_FMT;
          end
        end
        S_CD: begin
          if (~cd_rd & ~sd_ack) state <= S_IDLE;
        end
        S_REQ: begin
          if (ack_rise) begin
            rd_r  <= 1'b0;
            wr_r  <= 1'b0;
            state <= S_XFER;
          end
        end
        S_XFER: begin
          if (ack_fall) begin
            if (last_sector) begin
              state <= S_IDLE;
            end else begin
              lba   <= lba + 1'b1;
              rd_r  <= dir;
              wr_r  <= ~dir;
              state <= S_REQ;
            end
          end
        end
        S_FMT: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // CD pass-through is combinational; elsewhere the port carries our lba and
  // registered request strobes.
  always_comb begin
    sd_lba   = 32'(lba);
    sd_rd    = rd_r;
    sd_wr    = wr_r;
    cd_ack   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = 1'b0;
    case (state)
      S_CD: begin
        sd_lba = cd_lba;
        sd_rd  = cd_rd;
        sd_wr  = 1'b0;
        cd_ack = sd_ack;
      end
      S_XFER: begin
        // On a save the HPS reads port B q itself; only the address matters.
        ram_addr = 12'(xfer_addr);
        ram_din  = sd_buff_dout;
        ram_we   = dir & sd_ack & sd_buff_wr;
      end
      S_FMT: begin
        ram_addr = 12'(cnt);
        ram_we   = 1'b1;
        case (cnt)
          2'd0:    ram_din = 16'h5548;
          2'd1:    ram_din = 16'h4D42;
          2'd2:    ram_din = 16'h8800;
          default: ram_din = 16'h8010;
        endcase
      end
      default: ;
    endcase
  end

  assign busy    = (state == S_REQ) | (state == S_XFER) | (state == S_FMT);
  assign loading = dir & ((state == S_REQ) | (state == S_XFER));

endmodule

// File: tb/tb_bram_sd_ctrl.sv
module tb_bram_sd_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        bk_ena, bk_load, bk_save, auto_load, format;
  logic        busy, loading;
  logic [31:0] cd_lba;
  logic        cd_rd, cd_ack;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack;
  logic [7:0]  sd_buff_addr;
  logic        sd_buff_wr;
  logic [15:0] sd_buff_dout;
  logic [11:0] ram_addr;
  logic [15:0] ram_din;
  logic        ram_we;

  int vectors = 0;
  int miscompares = 0;

  // Reference image of the backup RAM, built from what the HPS delivered,
  // and the image actually written through port B.
  logic [15:0] exp_mem [4096];
  bit          exp_vld [4096];
  logic [15:0] got_mem [4096];

  bram_sd_ctrl dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .bk_ena(bk_ena), .bk_load(bk_load),
    .bk_save(bk_save), .auto_load(auto_load), .format(format), .busy(busy),
    .loading(loading), .cd_lba(cd_lba), .cd_rd(cd_rd), .cd_ack(cd_ack),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_wr(sd_buff_wr),
    .sd_buff_dout(sd_buff_dout), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) if (ram_we === 1'b1) got_mem[ram_addr] <= ram_din;

  // HPS side of a full 16-sector image transfer, checked against the rules:
  // one request per sector with lba 0..15, words land at n*256+i.
  task automatic run_xfer(input bit is_load);
    int t;
    logic [15:0] d;
    logic w, exp_we;
    logic [11:0] ea;
    for (int n = 0; n < 16; n++) begin
      t = 0;
      while (!(sd_rd === 1'b1 || sd_wr === 1'b1) && t < 20) begin
        @(negedge clk_sys); t++;
      end
      vectors++;
      if (!(sd_rd === 1'b1 || sd_wr === 1'b1)) begin
        $display("FAIL req_timeout sector %0d: no request seen", n);
        miscompares++;
        return;
      end
      vectors++;
      if (sd_lba !== 32'(n) || sd_rd !== is_load || sd_wr !== !is_load ||
          busy !== 1'b1 || loading !== is_load || cd_ack !== 1'b0) begin
        $display("FAIL req sector %0d: lba=%0h rd=%b wr=%b busy=%b loading=%b cd_ack=%b, want lba=%0h rd=%b wr=%b busy=1 loading=%b cd_ack=0",
                 n, sd_lba, sd_rd, sd_wr, busy, loading, cd_ack, n, is_load, !is_load, is_load);
        miscompares++;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk_sys);
      sd_ack = 1'b1;
      @(negedge clk_sys);
      vectors++;
      if (sd_rd !== 1'b0 || sd_wr !== 1'b0 || busy !== 1'b1) begin
        $display("FAIL req_drop sector %0d: rd=%b wr=%b busy=%b, want 0 0 1", n, sd_rd, sd_wr, busy);
        miscompares++;
      end
      for (int i = 0; i < 256; i++) begin
        d = 16'($urandom);
        w = is_load ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
        sd_buff_addr = 8'(i);
        sd_buff_dout = d;
        sd_buff_wr   = w;
        exp_we = is_load & w;
        ea = 12'(n * 256 + i);
        #1;
        vectors++;
        if (ram_we !== exp_we || ram_addr !== ea || (is_load && ram_din !== d) ||
            loading !== is_load || busy !== 1'b1) begin
          $display("FAIL word s%0d i%0d: we=%b addr=%h din=%h loading=%b busy=%b, want we=%b addr=%h din=%h loading=%b busy=1",
                   n, i, ram_we, ram_addr, ram_din, loading, busy, exp_we, ea, d, is_load);
          miscompares++;
        end
        if (exp_we) begin exp_mem[ea] = d; exp_vld[ea] = 1'b1; end
        @(negedge clk_sys);
      end
      sd_buff_wr = 1'b0;
      sd_ack = 1'b0;
      @(negedge clk_sys);
    end
    vectors++;
    if (busy !== 1'b0 || loading !== 1'b0 || sd_rd !== 1'b0 || sd_wr !== 1'b0) begin
      $display("FAIL xfer_end: busy=%b loading=%b rd=%b wr=%b, want all 0", busy, loading, sd_rd, sd_wr);
      miscompares++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; bk_ena = 1'b0; bk_load = 1'b0; bk_save = 1'b0;
    auto_load = 1'b0; format = 1'b0; cd_lba = '0; cd_rd = 1'b0;
    sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_wr = 1'b0; sd_buff_dout = '0;
    #12;
    vectors++;
    if ({sd_rd, sd_wr, cd_ack, ram_we, busy, loading} !== 6'b0 ||
        sd_lba !== 32'h0 || ram_addr !== 12'h0 || ram_din !== 16'h0) begin
      $display("FAIL reset: rd=%b wr=%b ack=%b we=%b busy=%b loading=%b lba=%h addr=%h din=%h, want all 0",
               sd_rd, sd_wr, cd_ack, ram_we, busy, loading, sd_lba, ram_addr, ram_din);
      miscompares++;
    end
    @(negedge clk_sys); reset_n = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic test_load;
    bk_ena = 1'b1; bk_load = 1'b1;
    run_xfer(1'b1);
    bk_load = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_save;
    bk_save = 1'b1;
    run_xfer(1'b0);
    bk_save = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_back_to_back;
    bk_load = 1'b1; bk_save = 1'b1;
    run_xfer(1'b1);
    run_xfer(1'b0);
    bk_load = 1'b0; bk_save = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_arbitration;
    cd_lba = 32'h1234; cd_rd = 1'b1; bk_load = 1'b1;
    @(negedge clk_sys);
    vectors++;
    if (sd_lba !== 32'h1234 || sd_rd !== 1'b1 || sd_wr !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL cd_own: lba=%h rd=%b wr=%b busy=%b, want 1234 1 0 0", sd_lba, sd_rd, sd_wr, busy);
      miscompares++;
    end
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk_sys);
      sd_ack = 1'b1; #1;
      vectors++;
      if (cd_ack !== 1'b1 || busy !== 1'b0 || loading !== 1'b0) begin
        $display("FAIL cd_ack_hi: cd_ack=%b busy=%b loading=%b, want 1 0 0", cd_ack, busy, loading);
        miscompares++;
      end
      @(negedge clk_sys);
      sd_ack = 1'b0; #1;
      vectors++;
      if (cd_ack !== 1'b0) begin
        $display("FAIL cd_ack_lo: cd_ack=%b, want 0", cd_ack);
        miscompares++;
      end
      @(negedge clk_sys);
    end
    // cd_rd drops while the HPS still acks: the port must stay with CD.
    cd_rd = 1'b0; sd_ack = 1'b1;
    @(negedge clk_sys);
    vectors++;
    if (cd_ack !== 1'b1 || busy !== 1'b0 || sd_rd !== 1'b0) begin
      $display("FAIL cd_hold: cd_ack=%b busy=%b rd=%b, want 1 0 0", cd_ack, busy, sd_rd);
      miscompares++;
    end
    sd_ack = 1'b0;
    run_xfer(1'b1);
    bk_load = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_ena_gate;
    bk_ena = 1'b0; bk_load = 1'b1;
    repeat (10) begin
      @(negedge clk_sys);
      vectors++;
      if (busy !== 1'b0 || sd_rd !== 1'b0 || sd_wr !== 1'b0) begin
        $display("FAIL ena_gate: busy=%b rd=%b wr=%b, want 0 0 0", busy, sd_rd, sd_wr);
        miscompares++;
      end
    end
    bk_load = 1'b0;
    repeat (2) @(negedge clk_sys);
    bk_ena = 1'b1; cd_rd = 1'b1; cd_lba = $urandom; bk_load = 1'b1;
    @(negedge clk_sys);
    bk_ena = 1'b0;
    @(negedge clk_sys);
    bk_ena = 1'b1; cd_rd = 1'b0; bk_load = 1'b0;
    repeat (10) begin
      @(negedge clk_sys);
      vectors++;
      if (busy !== 1'b0 || sd_rd !== 1'b0 || sd_wr !== 1'b0) begin
        $display("FAIL ena_clear: busy=%b rd=%b wr=%b, want 0 0 0", busy, sd_rd, sd_wr);
        miscompares++;
      end
    end
  endtask

  task automatic test_auto_load;
    bk_ena = 1'b1; auto_load = 1'b1;
    @(negedge clk_sys);
    auto_load = 1'b0;
    run_xfer(1'b1);
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_reset_mid;
    int t;
    logic [15:0] d;
    bk_ena = 1'b1; bk_load = 1'b1;
    t = 0;
    while (sd_rd !== 1'b1 && t < 20) begin @(negedge clk_sys); t++; end
    vectors++;
    if (sd_rd !== 1'b1) begin
      $display("FAIL rmid_req: rd=%b, want 1", sd_rd);
      miscompares++;
    end
    sd_ack = 1'b1;
    @(negedge clk_sys);
    for (int i = 0; i < 5; i++) begin
      d = 16'($urandom);
      sd_buff_addr = 8'(i); sd_buff_dout = d; sd_buff_wr = 1'b1;
      exp_mem[i] = d; exp_vld[i] = 1'b1;
      @(negedge clk_sys);
    end
    reset_n = 1'b0; #1;
    vectors++;
    if ({sd_rd, sd_wr, cd_ack, ram_we, busy, loading} !== 6'b0 ||
        sd_lba !== 32'h0 || ram_addr !== 12'h0 || ram_din !== 16'h0) begin
      $display("FAIL rmid_async: rd=%b wr=%b ack=%b we=%b busy=%b loading=%b lba=%h addr=%h din=%h, want all 0",
               sd_rd, sd_wr, cd_ack, ram_we, busy, loading, sd_lba, ram_addr, ram_din);
      miscompares++;
    end
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (10) begin
      @(negedge clk_sys);
      vectors++;
      if (busy !== 1'b0 || sd_rd !== 1'b0 || sd_wr !== 1'b0) begin
        $display("FAIL rmid_spurious: busy=%b rd=%b wr=%b, want 0 0 0", busy, sd_rd, sd_wr);
        miscompares++;
      end
    end
    bk_load = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_format;
    logic [15:0] hdr [4];
    int t;
    hdr[0] = 16'h5548; hdr[1] = 16'h4D42; hdr[2] = 16'h8800; hdr[3] = 16'h8010;
    bk_ena = 1'b0; format = 1'b1;
    t = 0;
    while (ram_we !== 1'b1 && t < 10) begin @(negedge clk_sys); t++; end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (ram_we !== 1'b1 || ram_addr !== 12'(k) || ram_din !== hdr[k] ||
          busy !== 1'b1 || sd_rd !== 1'b0 || sd_wr !== 1'b0) begin
        $display("FAIL fmt word %0d: we=%b addr=%h din=%h busy=%b rd=%b wr=%b, want 1 %h %h 1 0 0",
                 k, ram_we, ram_addr, ram_din, busy, sd_rd, sd_wr, 12'(k), hdr[k]);
        miscompares++;
      end
      exp_mem[k] = hdr[k]; exp_vld[k] = 1'b1;
      @(negedge clk_sys);
    end
    vectors++;
    if (ram_we !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL fmt_end: we=%b busy=%b, want 0 0", ram_we, busy);
      miscompares++;
    end
    format = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_mem_image;
    int diffs = 0;
    for (int a = 0; a < 4096; a++)
      if (exp_vld[a] && got_mem[a] !== exp_mem[a]) diffs++;
    vectors++;
    if (diffs != 0) begin
      $display("FAIL mem_image: %0d words differ, want 0", diffs);
      miscompares++;
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_save;
    test_back_to_back;
    test_arbitration;
    test_ena_gate;
    test_auto_load;
    test_reset_mid;
    test_format;
    test_mem_image;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bram_sd_ctrl.md
# bram_sd_ctrl

Backup-RAM save/load sequencer and SD-port arbiter for the TurboGrafx16 core. It shares the single hps_io sector port between the CD-ROM ISO reader (pcecd_top) and the 8 KB backup RAM. It moves 512-byte sectors between the HPS save file and the backup RAM port B. It also writes the default "HUBM" header on a format request.

## Interface
Parameters:
- SECTORS, 16: sectors per save image; must be a power of two, ≤256.
- LBA_W, 4: log2(SECTORS); sets the width of the sector counter.

Ports:
- clk_sys  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- bk_ena  in  1  writable save image is mounted.
- bk_load  in  1  status level; a rising edge requests a load.
- bk_save  in  1  status level; a rising edge requests a save.
- auto_load  in  1  one-cycle pulse at end of ROM download; requests a load.
- format  in  1  status level; a rising edge requests a format.
- busy  out  1  a backup operation (load, save or format) is in progress.
- loading  out  1  a load is in progress; top level ORs this into the core reset.
- cd_lba  in  32  ISO sector address from pcecd_top.
- cd_rd  in  1  ISO read request from pcecd_top.
- cd_ack  out  1  sd_ack routed back to pcecd_top.
- sd_lba  out  32  to hps_io.
- sd_rd  out  1  to hps_io.
- sd_wr  out  1  to hps_io.
- sd_ack  in  1  from hps_io.
- sd_buff_addr  in  8  word index within the current sector.
- sd_buff_wr  in  1  HPS write strobe.
- sd_buff_dout  in  16  HPS data to the core.
- ram_addr  out  12  backup RAM port B word address.
- ram_din  out  16  backup RAM port B write data.
- ram_we  out  1  backup RAM port B write enable.

## Operation
- Edge detectors on bk_load, bk_save and format set sticky pending flags.
  - Delay registers reset to 1, so a level already held through reset never triggers.
  - auto_load sets pend_load directly.
  - Pending load and pending save are cleared whenever bk_ena is 0. Format does not need bk_ena.
- States: IDLE, CD, REQ, XFER, FMT.
- IDLE chooses the next owner of the SD port, in this priority:
  1. If cd_rd=1 and sd_ack=0, go to CD.
  2. Otherwise pend_load, then pend_save, then pend_format.
  - For a load or save: lba←0, set dir (1=load), clear that pending flag, go to REQ.
  - For a format: cnt←0, clear pend_format, go to FMT.
- CD state:
  - sd_lba=cd_lba, sd_rd=cd_rd, sd_wr=0, cd_ack=sd_ack.
  - Return to IDLE when cd_rd=0 and sd_ack=0.
  - In every other state cd_ack=0. Outside CD, sd_lba = {zero-extended lba}.
- REQ: drive sd_rd=dir and sd_wr=~dir. On the rising edge of sd_ack, drop both and go to XFER.
- XFER:
  - ram_addr = {lba, sd_buff_addr}, truncated/zero-padded to 12 bits.
  - ram_din = sd_buff_dout.
  - ram_we = dir & sd_ack & sd_buff_wr, combinational.
  - For a save, the HPS reads port B q directly; this block only drives ram_addr.
  - On the falling edge of sd_ack: if lba = SECTORS-1, go to IDLE. Otherwise lba←lba+1 and go to REQ.
- FMT: write one word per cycle.
  - ram_addr=cnt and ram_we=1.
  - ram_din = 5548h, 4D42h, 8800h, 8010h for cnt = 0..3.
  - Go to IDLE after cnt=3.
- busy=1 in REQ, XFER and FMT. loading=1 in REQ and XFER when dir=1.
- A trigger edge during busy only sets the pending flag; it is served later.
- bk_ena falling mid-operation does not abort the transfer in progress.

## Timing
- Reset (async, reset_n=0):
  - State IDLE, all pending flags 0, lba=0, cnt=0.
  - Outputs sd_rd, sd_wr, cd_ack, ram_we, busy and loading are 0. sd_lba, ram_addr and ram_din are 0.
- IDLE→REQ takes 1 cycle. sd_rd/sd_wr are registered and assert on the first REQ cycle.
- sd_rd/sd_wr deassert the cycle after sd_ack is sampled high.
- Sector-to-sector gap is 1 cycle after sd_ack falls; the next request asserts on the following cycle.
- CD pass-through is combinational on sd_rd, sd_lba and cd_ack, with no added latency.
- Ownership changes only in IDLE with sd_ack=0, so a transfer is never split between owners.
- Format takes exactly 4 cycles with ram_we high, then busy drops.
- cd_rd and pend_load both ready in IDLE: CD wins; the load starts after CD returns to IDLE.
- bk_load and bk_save rising in the same cycle: load is served first, then save.

## Test plan
- Load: bk_ena=1, bk_load edge, HPS model returns sector n filled with word value n.
  - Expect 16 sd_rd requests with sd_lba 0..15.
  - Expect ram writes at addresses n*256+i with data n.
  - Expect loading high throughout, then busy=0.
- Save: bk_save edge.
  - Expect sd_wr with lba 0..15 and sd_rd=0 throughout.
  - Expect ram_addr to track {lba, sd_buff_addr} and ram_we never 1.
- Format edge:
  - Expect ram_we for 4 consecutive cycles with addresses 0..3 and data 5548h/4D42h/8800h/8010h.
  - No sd requests.
- Arbitration: cd_rd asserted with cd_lba=1234h during the same cycle as a bk_load edge.
  - sd_lba=1234h and cd_ack mirrors sd_ack.
  - The load starts only after cd_rd=0 and sd_ack=0.
- bk_ena=0 with a bk_load edge: no request and busy stays 0. bk_ena low also clears a load left pending while CD owned the port.
- reset_n low mid-XFER: all outputs are 0 immediately. After release, no spurious operation with bk_load still high.
